kmac_cmd_sched: RTL and testbench

//  Schedules ownership of the shared KMAC/SHA3 engine between NumApp hardware

---
 rtl/kmac_cmd_sched_if.sv | 52 +++++
 rtl/kmac_cmd_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_kmac_cmd_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmac_cmd_sched_if.sv
// Shared command/type package and the request/command bundle between the KMAC
// command scheduler and its app requesters, SW register block and SHA3 engine.
package kmac_cmd_sched_pkg;

   typedef enum logic [3:0] {
      CmdNone      = 4'b0000,
      CmdStart     = 4'b1101,
      CmdProcess   = 4'b0100,
      CmdManualRun = 4'b1001,
      CmdDone      = 4'b1011
   } kmac_cmd_e;

   typedef logic [3:0] mubi4_t;

   localparam mubi4_t MuBi4True = 4'h6;

endpackage

interface kmac_cmd_sched_if #(
   parameter int NumApp   = 3,
   parameter int TimeoutW = 16
);
   logic [NumApp-1:0]                 app_req_i;
   logic [NumApp-1:0]                 app_last_i;
   logic [NumApp-1:0]                 app_gnt_o;
   logic [NumApp-1:0]                 app_done_o;
   kmac_cmd_sched_pkg::kmac_cmd_e     sw_cmd_i;
   logic                              sw_dropped_o;
   kmac_cmd_sched_pkg::kmac_cmd_e     cmd_o;
   logic                              app_active_o;
   kmac_cmd_sched_pkg::mubi4_t        absorbed_i;
   logic                              err_valid_i;
   logic [TimeoutW-1:0]               timeout_cycles_i;
   logic                              clear_i;
   logic                              timeout_o;
   logic                              err_o;

   modport slave (
      input  app_req_i, app_last_i, sw_cmd_i, absorbed_i, err_valid_i,
             timeout_cycles_i, clear_i,
      output app_gnt_o, app_done_o, sw_dropped_o, cmd_o, app_active_o,
             timeout_o, err_o
   );

   modport master (
      output app_req_i, app_last_i, sw_cmd_i, absorbed_i, err_valid_i,
             timeout_cycles_i, clear_i,
      input  app_gnt_o, app_done_o, sw_dropped_o, cmd_o, app_active_o,
             timeout_o, err_o
   );

endinterface

// File: rtl/kmac_cmd_sched.sv
// Arbitrates the KMAC/SHA3 engine between hardware apps (round-robin) and SW,
// generating Start/Process/Done for app owners and forwarding SW commands.
module kmac_cmd_sched
   import kmac_cmd_sched_pkg::*;
#(
   parameter int NumApp   = 3,
   parameter int TimeoutW = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   kmac_cmd_sched_if.slave bus
);

   localparam int IdxW = (NumApp > 1) ? $clog2(NumApp) : 1;
   localparam logic [NumApp-1:0] OneHot0 = NumApp'(1'b1);

   // Sparse state codes, pairwise Hamming distance of at least 3.
   typedef enum logic [5:0] {
      StIdle  = 6'b000000,
      StStart = 6'b000111,
      StFeed  = 6'b011001,
      StWait  = 6'b101010,
      StDone  = 6'b110100,
      StSwOwn = 6'b011110,
      StError = 6'b101101
   } state_e;

   state_e              state_r;
   logic [IdxW-1:0]     owner_r;
   logic [IdxW-1:0]     rr_ptr_r;
   logic [TimeoutW-1:0] cnt_r;
   logic [NumApp-1:0]   gnt_r;
   logic [NumApp-1:0]   done_r;
   kmac_cmd_e           cmd_r;
   logic                active_r;
   logic                timeout_r;
   logic                err_r;
   logic                dropped_r;

   logic [IdxW-1:0]     win_s;
   logic [IdxW-1:0]     ptr_next_s;
   logic [TimeoutW-1:0] cnt_next_s;
   logic                timeout_hit_s;
   logic                absorbed_s;
   logic                sw_busy_s;
   logic                owner_last_s;
   logic                app_owned_s;

   function automatic logic [IdxW-1:0] rr_pick(input logic [NumApp-1:0] req,
                                               input logic [IdxW-1:0]   ptr);
      logic [IdxW-1:0] pick;
      logic [IdxW-1:0] cand;
      logic            found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NumApp; k++) begin
         cand = IdxW'((int'(ptr) + k) % NumApp);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
      logic [IdxW-1:0] nxt;
      if (idx >= IdxW'(NumApp - 1)) begin
         nxt = '0;
      end else begin
         nxt = idx + IdxW'(1);
      end
      return nxt;
   endfunction

   // Arbitration winner, saturating wait-counter step and input decodes.
   always_comb begin
      win_s        = rr_pick(bus.app_req_i, rr_ptr_r);
      ptr_next_s   = wrap_inc(owner_r);
      absorbed_s   = (bus.absorbed_i == MuBi4True);
      sw_busy_s    = (bus.sw_cmd_i != CmdNone);
      owner_last_s = bus.app_last_i[owner_r];
      if (cnt_r == {TimeoutW{1'b1}}) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + TimeoutW'(1);
      end
      timeout_hit_s = (bus.timeout_cycles_i != '0) && (cnt_next_s >= bus.timeout_cycles_i);
      case (state_r)
         StStart, StFeed, StWait, StDone: app_owned_s = 1'b1;
         default:                         app_owned_s = 1'b0;
      endcase
   end

   // Scheduler FSM; every output is registered from the next-state decision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= StIdle;
         owner_r   <= '0;
         rr_ptr_r  <= '0;
         cnt_r     <= '0;
         gnt_r     <= '0;
         done_r    <= '0;
         cmd_r     <= CmdNone;
         active_r  <= 1'b0;
         timeout_r <= 1'b0;
         err_r     <= 1'b0;
         dropped_r <= 1'b0;
      end else begin
         done_r    <= '0;
         timeout_r <= 1'b0;
         dropped_r <= 1'b0;
         if (app_owned_s && bus.err_valid_i) begin
            // Abort without completion; the failed owner loses its RR turn.
            state_r   <= StError;
            err_r     <= 1'b1;
            gnt_r     <= '0;
            active_r  <= 1'b0;
            cmd_r     <= CmdNone;
            rr_ptr_r  <= ptr_next_s;
            dropped_r <= sw_busy_s;
         end else begin
            case (state_r)
               StIdle: begin
                  cnt_r <= '0;
                  if (|bus.app_req_i) begin
                     state_r   <= StStart;
                     owner_r   <= win_s;
                     gnt_r     <= OneHot0 << win_s;
                     active_r  <= 1'b1;
                     cmd_r     <= CmdStart;
                     dropped_r <= (bus.sw_cmd_i == CmdStart);
                  end else if (bus.sw_cmd_i == CmdStart) begin
                     state_r <= StSwOwn;
                     cmd_r   <= CmdStart;
                  end else begin
                     cmd_r <= CmdNone;
                  end
               end
               StStart: begin
                  state_r   <= StFeed;
                  cmd_r     <= CmdNone;
                  dropped_r <= sw_busy_s;
               end
               StFeed: begin
                  dropped_r <= sw_busy_s;
                  cnt_r     <= '0;
                  if (owner_last_s) begin
                     state_r <= StWait;
                     cmd_r   <= CmdProcess;
                  end else begin
                     cmd_r <= CmdNone;
                  end
               end
               StWait: begin
                  dropped_r <= sw_busy_s;
                  cnt_r     <= cnt_next_s;
                  if (absorbed_s) begin
                     state_r <= StDone;
                     cmd_r   <= CmdDone;
                     done_r  <= OneHot0 << owner_r;
                  end else if (timeout_hit_s) begin
                     state_r   <= StError;
                     cmd_r     <= CmdNone;
                     timeout_r <= 1'b1;
                     err_r     <= 1'b1;
                     gnt_r     <= '0;
                     active_r  <= 1'b0;
                     rr_ptr_r  <= ptr_next_s;
                  end else begin
                     cmd_r <= CmdNone;
                  end
               end
               StDone: begin
                  state_r   <= StIdle;
                  cmd_r     <= CmdNone;
                  gnt_r     <= '0;
                  active_r  <= 1'b0;
                  rr_ptr_r  <= ptr_next_s;
                  dropped_r <= sw_busy_s;
               end
               StSwOwn: begin
                  cmd_r <= bus.sw_cmd_i;
                  if (bus.sw_cmd_i == CmdDone) begin
                     state_r <= StIdle;
                  end else begin
                     state_r <= StSwOwn;
                  end
               end
               StError: begin
                  cmd_r     <= CmdNone;
                  dropped_r <= sw_busy_s;
                  if (bus.clear_i) begin
                     state_r <= StIdle;
                     err_r   <= 1'b0;
                     cnt_r   <= '0;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= StError;
                  err_r    <= 1'b1;
                  gnt_r    <= '0;
                  active_r <= 1'b0;
                  cmd_r    <= CmdNone;
               end
            endcase
         end
      end
   end

   assign bus.app_gnt_o    = gnt_r;
   assign bus.app_done_o   = done_r;
   assign bus.cmd_o        = cmd_r;
   assign bus.app_active_o = active_r;
   assign bus.timeout_o    = timeout_r;
   assign bus.err_o        = err_r;
   assign bus.sw_dropped_o = dropped_r;

endmodule

// File: tb/tb_kmac_cmd_sched.sv
// Bench for kmac_cmd_sched: vector table, directed corner sequences, and a
// randomized run against an ownership-level reference model.
module tb_kmac_cmd_sched;
   import kmac_cmd_sched_pkg::*;

   localparam int N  = 3;
   localparam int TW = 16;
   localparam logic [3:0] MuTrue  = 4'h6;
   localparam logic [3:0] MuFalse = 4'h9;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   kmac_cmd_sched_if #(.NumApp(N), .TimeoutW(TW)) bus ();
   kmac_cmd_sched #(.NumApp(N), .TimeoutW(TW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [N-1:0] req;
      logic [N-1:0] last;
      kmac_cmd_e    sw;
      logic [3:0]   absorbed;
      logic [N-1:0] exp_gnt;
      logic [N-1:0] exp_done;
      kmac_cmd_e    exp_cmd;
      logic         exp_drop;
   } vec_t;
   vec_t vecs [12];

   // reference model: who owns the engine and how far its hash has progressed
   int           m_owner, m_step, m_wait, m_rr;
   bit           m_sw, m_err;
   logic [N-1:0] e_gnt, e_done;
   kmac_cmd_e    e_cmd;
   logic         e_active, e_timeout, e_err, e_drop;

   logic [N-1:0] r_req, r_last;
   kmac_cmd_e    r_sw;
   logic [3:0]   r_abs;
   logic         r_err, r_clr;
   int           r_tmo;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] last, input kmac_cmd_e sw,
                        input logic [3:0] absv, input logic errv, input logic clr);
      bus.app_req_i   = req;
      bus.app_last_i  = last;
      bus.sw_cmd_i    = sw;
      bus.absorbed_i  = absv;
      bus.err_valid_i = errv;
      bus.clear_i     = clr;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_owner = -1; m_step = 0; m_wait = 0; m_rr = 0; m_sw = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_abort();
      m_rr = (m_owner + 1) % N; m_owner = -1; m_err = 1'b1;
   endtask

   task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] last, input kmac_cmd_e sw,
                             input logic [3:0] absv, input logic errv, input logic clr, input int tmo);
      bit found;
      e_done = '0; e_timeout = 1'b0; e_drop = 1'b0; e_cmd = CmdNone;
      if (m_err) begin
         e_drop = (sw != CmdNone);
         if (clr) m_err = 1'b0;
      end else if (m_sw) begin
         e_cmd = sw;
         if (sw == CmdDone) m_sw = 1'b0;
      end else if (m_owner < 0) begin
         if (req != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!found && req[(m_rr + k) % N]) begin
                  m_owner = (m_rr + k) % N;
                  found   = 1'b1;
               end
            end
            m_step = 0;
            e_cmd  = CmdStart;
            e_drop = (sw == CmdStart);
         end else if (sw == CmdStart) begin
            m_sw  = 1'b1;
            e_cmd = CmdStart;
         end
      end else begin
         e_drop = (sw != CmdNone);
         if (errv) begin
            model_abort();
         end else if (m_step == 0) begin
            m_step = 1;
         end else if (m_step == 1) begin
            if (last[m_owner]) begin
               e_cmd = CmdProcess; m_step = 2; m_wait = 0;
            end
         end else if (m_step == 2) begin
            m_wait++;
            if (absv == MuTrue) begin
               e_cmd = CmdDone; e_done = N'(1) << m_owner; m_step = 3;
            end else if (tmo != 0 && m_wait >= tmo) begin
               e_timeout = 1'b1;
               model_abort();
            end
         end else begin
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
      e_gnt    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_active = (m_owner >= 0);
      e_err    = m_err;
   endtask

   initial begin
      vecs[0]  = '{3'b101, 3'b000, CmdNone,    MuFalse, 3'b001, 3'b000, CmdStart,   1'b0};
      vecs[1]  = '{3'b101, 3'b000, CmdNone,    MuFalse, 3'b001, 3'b000, CmdNone,    1'b0};
      vecs[2]  = '{3'b101, 3'b001, CmdNone,    MuFalse, 3'b001, 3'b000, CmdProcess, 1'b0};
      vecs[3]  = '{3'b101, 3'b000, CmdNone,    MuTrue,  3'b001, 3'b001, CmdDone,    1'b0};
      vecs[4]  = '{3'b100, 3'b000, CmdNone,    MuFalse, 3'b000, 3'b000, CmdNone,    1'b0};
      vecs[5]  = '{3'b100, 3'b000, CmdNone,    MuFalse, 3'b100, 3'b000, CmdStart,   1'b0};
      vecs[6]  = '{3'b100, 3'b001, CmdNone,    MuFalse, 3'b100, 3'b000, CmdNone,    1'b0};
      vecs[7]  = '{3'b100, 3'b001, CmdProcess, MuFalse, 3'b100, 3'b000, CmdNone,    1'b1};
      vecs[8]  = '{3'b100, 3'b100, CmdNone,    MuFalse, 3'b100, 3'b000, CmdProcess, 1'b0};
      vecs[9]  = '{3'b100, 3'b000, CmdNone,    4'hE,    3'b100, 3'b000, CmdNone,    1'b0};
      vecs[10] = '{3'b100, 3'b000, CmdNone,    MuTrue,  3'b100, 3'b100, CmdDone,    1'b0};
      vecs[11] = '{3'b000, 3'b000, CmdNone,    MuFalse, 3'b000, 3'b000, CmdNone,    1'b0};

      rst_n = 1'b0;
      drive('0, '0, CmdNone, MuFalse, 1'b0, 1'b0);
      bus.timeout_cycles_i = '0;
      repeat (2) @(negedge clk);
      chk("rst.gnt", bus.app_gnt_o, 3'b000);
      chk("rst.done", bus.app_done_o, 3'b000);
      chk("rst.cmd", bus.cmd_o, CmdNone);
      chk("rst.active", bus.app_active_o, 1'b0);
      chk("rst.timeout", bus.timeout_o, 1'b0);
      chk("rst.err", bus.err_o, 1'b0);
      chk("rst.dropped", bus.sw_dropped_o, 1'b0);
      rst_n = 1'b1;

      // apps 0 and 2 together from reset, round-robin hand-over
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].req, vecs[i].last, vecs[i].sw, vecs[i].absorbed, 1'b0, 1'b0);
         step();
         chk($sformatf("vec%0d.gnt", i), bus.app_gnt_o, vecs[i].exp_gnt);
         chk($sformatf("vec%0d.done", i), bus.app_done_o, vecs[i].exp_done);
         chk($sformatf("vec%0d.cmd", i), bus.cmd_o, vecs[i].exp_cmd);
         chk($sformatf("vec%0d.drop", i), bus.sw_dropped_o, vecs[i].exp_drop);
         chk($sformatf("vec%0d.active", i), bus.app_active_o, |vecs[i].exp_gnt);
      end

      // app 1 and SW Start collide in idle: app wins, SW dropped
      drive(3'b010, 3'b000, CmdStart, MuFalse, 1'b0, 1'b0); step();
      chk("coll.gnt", bus.app_gnt_o, 3'b010);
      chk("coll.drop", bus.sw_dropped_o, 1'b1);
      chk("coll.active", bus.app_active_o, 1'b1);
      drive(3'b010, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("coll.cmd_none", bus.cmd_o, CmdNone);
      drive(3'b010, 3'b010, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("coll.process", bus.cmd_o, CmdProcess);
      drive(3'b010, 3'b000, CmdNone, MuTrue, 1'b0, 1'b0); step();
      chk("coll.done", bus.app_done_o, 3'b010);
      drive(3'b000, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("coll.release", bus.app_gnt_o, 3'b000);

      // SW ownership: echoed with one cycle latency, app request waits
      drive(3'b000, 3'b000, CmdStart, MuFalse, 1'b0, 1'b0); step();
      chk("sw.start", bus.cmd_o, CmdStart);
      chk("sw.active0", bus.app_active_o, 1'b0);
      drive(3'b001, 3'b000, CmdProcess, MuFalse, 1'b0, 1'b0); step();
      chk("sw.process", bus.cmd_o, CmdProcess);
      chk("sw.app_waits", bus.app_gnt_o, 3'b000);
      drive(3'b001, 3'b000, CmdDone, MuFalse, 1'b0, 1'b0); step();
      chk("sw.done", bus.cmd_o, CmdDone);
      chk("sw.active1", bus.app_active_o, 1'b0);

      // absorb never arrives: timeout after 4 wait cycles
      bus.timeout_cycles_i = 16'd4;
      drive(3'b001, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("tmo.gnt", bus.app_gnt_o, 3'b001);
      step();
      drive(3'b001, 3'b001, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("tmo.process", bus.cmd_o, CmdProcess);
      drive(3'b001, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("tmo.early%0d", k), bus.timeout_o, 1'b0);
      end
      step();
      chk("tmo.pulse", bus.timeout_o, 1'b1);
      chk("tmo.err", bus.err_o, 1'b1);
      chk("tmo.gnt_drop", bus.app_gnt_o, 3'b000);
      drive(3'b000, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("tmo.pulse_end", bus.timeout_o, 1'b0);
      chk("tmo.err_hold", bus.err_o, 1'b1);
      drive(3'b000, 3'b000, CmdNone, MuFalse, 1'b0, 1'b1); step();
      chk("tmo.clear", bus.err_o, 1'b0);

      // absorb on the same cycle the limit is reached wins over timeout
      drive(3'b010, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("race.gnt", bus.app_gnt_o, 3'b010);
      step();
      drive(3'b010, 3'b010, CmdNone, MuFalse, 1'b0, 1'b0); step();
      drive(3'b010, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0);
      repeat (3) step();
      drive(3'b010, 3'b000, CmdNone, MuTrue, 1'b0, 1'b0); step();
      chk("race.done", bus.app_done_o, 3'b010);
      chk("race.no_tmo", bus.timeout_o, 1'b0);
      chk("race.cmd", bus.cmd_o, CmdDone);
      drive(3'b000, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();

      // error while feeding: no done, then RR moves past the failed owner
      bus.timeout_cycles_i = '0;
      drive(3'b100, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("err.gnt", bus.app_gnt_o, 3'b100);
      step();
      drive(3'b100, 3'b000, CmdNone, MuFalse, 1'b1, 1'b0); step();
      chk("err.err", bus.err_o, 1'b1);
      chk("err.gnt_drop", bus.app_gnt_o, 3'b000);
      chk("err.no_done", bus.app_done_o, 3'b000);
      drive(3'b100, 3'b000, CmdProcess, MuFalse, 1'b0, 1'b0); step();
      chk("err.sw_drop", bus.sw_dropped_o, 1'b1);
      chk("err.cmd", bus.cmd_o, CmdNone);
      drive(3'b000, 3'b000, CmdNone, MuFalse, 1'b0, 1'b1); step();
      chk("err.clear", bus.err_o, 1'b0);
      drive(3'b111, 3'b000, CmdNone, MuFalse, 1'b0, 1'b0); step();
      chk("err.rr_next", bus.app_gnt_o, 3'b001);

      // asynchronous reset mid-operation
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst.gnt", bus.app_gnt_o, 3'b000);
      chk("arst.cmd", bus.cmd_o, CmdNone);
      chk("arst.active", bus.app_active_o, 1'b0);
      drive('0, '0, CmdNone, MuFalse, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // randomized traffic against the reference model
      r_req = '0;
      r_tmo = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int a = 0; a < N; a++) begin
            if (!r_req[a] && $urandom_range(0, 7) == 0) r_req[a] = 1'b1;
         end
         r_last = N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1));
         case ($urandom_range(0, 15))
            0:       r_sw = CmdStart;
            1:       r_sw = CmdProcess;
            2:       r_sw = CmdDone;
            3:       r_sw = CmdManualRun;
            default: r_sw = CmdNone;
         endcase
         case ($urandom_range(0, 7))
            0, 1:    r_abs = MuTrue;
            2:       r_abs = 4'h0;
            3:       r_abs = 4'hE;
            4:       r_abs = 4'h7;
            default: r_abs = MuFalse;
         endcase
         r_err = ($urandom_range(0, 59) == 0);
         r_clr = ($urandom_range(0, 3) == 0);
         if (c % 200 == 0) r_tmo = $urandom_range(0, 8);
         bus.timeout_cycles_i = TW'(r_tmo);
         drive(r_req, r_last, r_sw, r_abs, r_err, r_clr);
         model_step(r_req, r_last, r_sw, r_abs, r_err, r_clr, r_tmo);
         step();
         chk($sformatf("rand%0d{gnt,done,cmd,act,tmo,err,drop}", c),
             {bus.app_gnt_o, bus.app_done_o, bus.cmd_o, bus.app_active_o,
              bus.timeout_o, bus.err_o, bus.sw_dropped_o},
             {e_gnt, e_done, e_cmd, e_active, e_timeout, e_err, e_drop});
         r_req = r_req & ~e_done;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
